// File: rtl/project_switch_controller.sv
// Wishbone-controlled project switcher: isolates pads, resets the newly selected project, then releases.
// Optional `AUTO_ROTATE_EN adds a period register that self-requests the next project after idle time.
module project_switch_controller #(
    parameter logic [31:0] ADDRESS_CTRL   = 32'h30000000,
    parameter logic [31:0] ADDRESS_STATUS = 32'h30000004,
    parameter logic [31:0] ADDRESS_ROTATE = 32'h30000008,
    parameter int          NUM_PROJECTS   = 4,
    parameter int          ISOLATE_CYCLES = 4,
    parameter int          RESET_CYCLES   = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [7:0]              active_project_o,
    output logic [NUM_PROJECTS-1:0] project_reset_o,
    output logic                    io_isolate_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISOLATE = 2'd1,
        S_RESET   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] ISO_LAST  = 8'(ISOLATE_CYCLES - 1);
    localparam logic [7:0] RST_LAST  = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] NUM_P     = 8'(NUM_PROJECTS);
    localparam logic [7:0] LAST_P    = 8'(NUM_PROJECTS - 1);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [7:0]  active_q, request_q, target_q;
    logic        pending_q, err_q, ack_q, ack_done_q;
    logic [31:0] dat_q, rdata, rot_rdata;

    logic valid, hit_ctrl, hit_status, hit_rotate, mapped, accept, wr;
    logic ctrl_wr, ctrl_ok, consume, rotate_fire;
    logic [7:0] rotate_next;

    assign valid      = wbs_cyc_i & wbs_stb_i;
    assign hit_ctrl   = (wbs_adr_i == ADDRESS_CTRL);
    assign hit_status = (wbs_adr_i == ADDRESS_STATUS);
    assign mapped     = hit_ctrl | hit_status | hit_rotate;
    // One ack per bus transfer: a transfer still held after its ack is ignored until the bus drops.
    assign accept     = valid & mapped & ~ack_done_q;
    assign wr         = accept & wbs_we_i & wbs_sel_i[0];
    assign ctrl_wr    = wr & hit_ctrl;
    assign ctrl_ok    = ctrl_wr & (wbs_dat_i[7:0] < NUM_P);
    assign consume    = (state_q == S_IDLE) & pending_q;
    assign rotate_next = (active_q == LAST_P) ? 8'd0 : active_q + 8'd1;

`ifdef AUTO_ROTATE_EN
    logic [15:0] period_q, rot_cnt_q;

    assign hit_rotate  = (wbs_adr_i == ADDRESS_ROTATE);
    assign rot_rdata   = {16'b0, period_q};
    assign rotate_fire = (period_q != 16'd0) && (state_q == S_IDLE) && !pending_q
                         && (rot_cnt_q >= period_q - 16'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            period_q  <= 16'd0;
            rot_cnt_q <= 16'd0;
        end else begin
            if (wr && hit_rotate)
                period_q <= wbs_dat_i[15:0];
            if (state_q != S_IDLE || pending_q || rotate_fire)
                rot_cnt_q <= 16'd0;
            else if (period_q != 16'd0)
                rot_cnt_q <= rot_cnt_q + 16'd1;
        end
    end
`else
    assign hit_rotate  = 1'b0;
    assign rot_rdata   = 32'd0;
    assign rotate_fire = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        phase_d = 8'd0;
        case (state_q)
            S_IDLE:    if (pending_q) state_d = S_ISOLATE;
            S_ISOLATE: if (phase_q == ISO_LAST) state_d = S_RESET;
                       else phase_d = phase_q + 8'd1;
            S_RESET:   if (phase_q == RST_LAST) state_d = S_RELEASE;
                       else phase_d = phase_q + 8'd1;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (wb_rst_i) begin
            state_q <= S_RESET;
            phase_q <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit_status)
            rdata = {18'b0, state_q, 1'b0, err_q, pending_q, (state_q != S_IDLE), active_q};
        else if (hit_ctrl)
            rdata = {24'b0, active_q};
        else if (hit_rotate)
            rdata = rot_rdata;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            active_q   <= 8'd0;
            request_q  <= 8'd0;
            target_q   <= 8'd0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            ack_done_q <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            ack_q      <= accept;
            ack_done_q <= valid & (ack_done_q | accept);
            dat_q      <= (accept && !wbs_we_i) ? rdata : 32'd0;

            if (accept && !wbs_we_i && hit_status)
                err_q <= 1'b0;
            if (ctrl_wr && !ctrl_ok)
                err_q <= 1'b1;

            // Latch the target on consumption so later writes only affect the next sequence.
            if (consume) begin
                target_q  <= request_q;
                pending_q <= 1'b0;
            end
            if (ctrl_ok) begin
                request_q <= wbs_dat_i[7:0];
                pending_q <= 1'b1;
            end else if (rotate_fire) begin
                request_q <= rotate_next;
                pending_q <= 1'b1;
            end

            if (state_q != S_RESET && state_d == S_RESET)
                active_q <= target_q;
        end
    end

    always_comb begin
        project_reset_o = '1;
        for (int i = 0; i < NUM_PROJECTS; i++)
            if (active_q == 8'(i) && state_q != S_RESET)
                project_reset_o[i] = 1'b0;
    end

    assign io_isolate_o     = (state_q != S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign active_project_o = active_q;
    assign wbs_ack_o        = ack_q;
    assign wbs_dat_o        = dat_q;

endmodule
